// File: rtl/load_store_unit.sv
// Load/store unit: turns a MEM-stage load or store into one doubleword memory
// transaction and returns the byte-lane-extracted, extended load result.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_M,
    input  logic        mem_write_M,
    input  logic [2:0]  func3_M,
    input  logic [63:0] addr_M,
    input  logic [63:0] wdata_M,
    output logic [63:0] rdata,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        dm_req,
    input  logic        dm_gnt,
    output logic        dm_we,
    output logic [7:0]  dm_be,
    output logic [60:0] dm_addr,
    output logic [63:0] dm_wdata,
    input  logic        dm_rvalid,
    input  logic [63:0] dm_rdata,
    output logic [1:0]  dbg_state_o
);

    // Memory handshake: a request transfers on a cycle where dm_req and dm_gnt
    // are both high; until then dm_req and the whole dm_* payload stay stable.
    // dm_rvalid is a one-cycle strobe without back-pressure and only counts
    // once the request has been granted (it may coincide with the grant).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        we_q;
    logic [7:0]  be_q;
    logic [60:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;

    logic        access_in;
    logic        load_in;
    logic        mis_in;
    logic [7:0]  mask_in;
    logic [7:0]  be_in;
    logic [63:0] wdata_in;

    logic        req_c;
    logic        stall_c;
    logic        mis_c;
    logic        accept_c;
    logic        capture_c;

    logic [2:0]  sel_off;
    logic [2:0]  sel_f3;
    logic [63:0] ld_shift;
    logic [63:0] ld_val;

    // Both strobes high counts as a store.
    assign access_in = mem_read_M | mem_write_M;
    assign load_in   = mem_read_M & ~mem_write_M;

    // func3[1:0] encodes size for every code, so 111 falls in with d.
    always_comb begin
        mis_in  = 1'b0;
        mask_in = 8'hFF;
        unique case (func3_M[1:0])
            2'b00: begin
                mis_in  = 1'b0;
                mask_in = 8'h01;
            end
            2'b01: begin
                mis_in  = addr_M[0];
                mask_in = 8'h03;
            end
            2'b10: begin
                mis_in  = |addr_M[1:0];
                mask_in = 8'h0F;
            end
            default: begin
                mis_in  = |addr_M[2:0];
                mask_in = 8'hFF;
            end
        endcase
    end

    assign be_in    = mask_in << addr_M[2:0];
    assign wdata_in = wdata_M << {addr_M[2:0], 3'b000};

    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        mis_c     = 1'b0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access_in) begin
                    if (mis_in) begin
                        mis_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        req_c    = 1'b1;
                        stall_c  = 1'b1;
                        if (dm_gnt && dm_rvalid) begin
                            state_d   = S_DONE;
                            capture_c = load_in;
                        end else if (dm_gnt) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dm_gnt && dm_rvalid) begin
                    state_d   = S_DONE;
                    capture_c = load_q;
                end else if (dm_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (dm_rvalid) begin
                    state_d   = S_DONE;
                    capture_c = load_q;
                end
            end
            default: begin
                // The held instruction is still on the inputs here; it is
                // deliberately not looked at so it cannot be reissued.
                state_d = S_IDLE;
            end
        endcase
    end

    // A same-cycle grant+response in IDLE completes before the latch settles.
    assign sel_off  = (state_q == S_IDLE) ? addr_M[2:0] : off_q;
    assign sel_f3   = (state_q == S_IDLE) ? func3_M     : f3_q;
    assign ld_shift = dm_rdata >> {sel_off, 3'b000};

    always_comb begin
        ld_val = ld_shift;
        unique case (sel_f3)
            3'b000:  ld_val = {{56{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_val = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_val = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b100:  ld_val = {56'd0, ld_shift[7:0]};
            3'b101:  ld_val = {48'd0, ld_shift[15:0]};
            3'b110:  ld_val = {32'd0, ld_shift[31:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            off_q   <= 3'd0;
            f3_q    <= 3'd0;
            load_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 8'd0;
            addr_q  <= 61'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                off_q   <= addr_M[2:0];
                f3_q    <= func3_M;
                load_q  <= load_in;
                we_q    <= mem_write_M;
                be_q    <= be_in;
                addr_q  <= addr_M[63:3];
                wdata_q <= wdata_in;
            end
            if (capture_c) begin
                rdata_q <= ld_val;
            end
        end
    end

    assign dm_req      = req_c & ~reset;
    assign mem_stall   = stall_c & ~reset;
    assign misaligned  = mis_c & ~reset;
    assign dm_we       = (state_q == S_IDLE) ? mem_write_M   : we_q;
    assign dm_be       = (state_q == S_IDLE) ? be_in         : be_q;
    assign dm_addr     = (state_q == S_IDLE) ? addr_M[63:3]  : addr_q;
    assign dm_wdata    = (state_q == S_IDLE) ? wdata_in      : wdata_q;
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// multi-cycle corner sequences, then randomized accesses against a byte model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_M, mem_write_M;
    logic [2:0]  func3_M;
    logic [63:0] addr_M, wdata_M;
    logic [63:0] rdata;
    logic        mem_stall, misaligned, dm_req, dm_gnt, dm_we, dm_rvalid;
    logic [7:0]  dm_be;
    logic [60:0] dm_addr;
    logic [63:0] dm_wdata, dm_rdata;
    logic [1:0]  dbg_state_o;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd2;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .mem_read_M(mem_read_M), .mem_write_M(mem_write_M), .func3_M(func3_M),
        .addr_M(addr_M), .wdata_M(wdata_M), .rdata(rdata),
        .mem_stall(mem_stall), .misaligned(misaligned),
        .dm_req(dm_req), .dm_gnt(dm_gnt), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_rdata = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2 || f3 == 3'd6) return 4;
        return 8;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [63:0] dword);
        int          n = size_bytes(f3);
        logic [63:0] v = 64'd0;
        logic [7:0]  b;
        bit          sgn = (f3 < 3'd3);
        for (int i = 0; i < n; i++) begin
            b = dword[8*(off+i) +: 8];
            v = v | (64'(b) << (8*i));
        end
        if (sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    function automatic logic [7:0] model_be(input logic [2:0] f3, input int off);
        int m = (1 << size_bytes(f3)) - 1;
        return 8'((m << off) & 255);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_req(input string tag, input logic wr, input logic [7:0] ebe,
                             input logic [63:0] addr, input logic [63:0] ewd);
        chk({tag, " dm_req"}, 64'(dm_req), 64'd1);
        chk({tag, " stall"},  64'(mem_stall), 64'd1);
        chk({tag, " misal"},  64'(misaligned), 64'd0);
        chk({tag, " we"},     64'(dm_we), 64'(wr));
        chk({tag, " be"},     64'(dm_be), 64'(ebe));
        chk({tag, " addr"},   64'(dm_addr), 64'(addr[63:3]));
        if (wr) chk({tag, " wdata"}, dm_wdata, ewd);
        chk({tag, " rdata_hold"}, rdata, last_rdata);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        mem_read_M = 1'b0; mem_write_M = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'($urandom_range(0, 1));
        dm_rdata = {$urandom, $urandom};
        #1;
        chk({tag, " idle req"},   64'(dm_req), 64'd0);
        chk({tag, " idle stall"}, 64'(mem_stall), 64'd0);
        chk({tag, " idle misal"}, 64'(misaligned), 64'd0);
        chk({tag, " idle rdata"}, rdata, last_rdata);
    endtask

    // gd: cycles in REQ before grant; rvd: extra WAIT cycles before rvalid;
    // same: rvalid arrives together with the grant.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] dword, input int gd, input int rvd,
                             input bit same, input logic [7:0] ebe,
                             input logic [63:0] ewd, input logic [63:0] erd,
                             input string tag);
        logic        is_load;
        logic [63:0] e;
        is_load = rd & ~wr;
        if (is_load) exp_q.push_back(erd);
        @(negedge clk);
        mem_read_M = rd; mem_write_M = wr; func3_M = f3; addr_M = addr; wdata_M = wd;
        dm_gnt = (gd == 0);
        dm_rvalid = same && (gd == 0);
        dm_rdata = dm_rvalid ? dword : ~dword;
        #1 check_req({tag, " issue"}, wr, ebe, addr, ewd);
        for (int k = 1; k <= gd; k++) begin
            @(negedge clk);
            dm_gnt = (k == gd);
            dm_rvalid = (k == gd) ? same : 1'($urandom_range(0, 1));
            dm_rdata = (k == gd && same) ? dword : ~dword;
            #1 check_req({tag, " hold"}, wr, ebe, addr, ewd);
        end
        if (!same) begin
            for (int k = 0; k <= rvd; k++) begin
                @(negedge clk);
                dm_gnt = 1'b0;
                dm_rvalid = (k == rvd);
                dm_rdata = dm_rvalid ? dword : ~dword;
                #1;
                chk({tag, " wait req"},   64'(dm_req), 64'd0);
                chk({tag, " wait stall"}, 64'(mem_stall), 64'd1);
            end
        end
        @(negedge clk);
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = ~dword;
        #1;
        chk({tag, " done stall"}, 64'(mem_stall), 64'd0);
        chk({tag, " done req"},   64'(dm_req), 64'd0);
        if (is_load) begin
            e = exp_q.pop_front();
            chk({tag, " rdata"}, rdata, e);
            last_rdata = e;
        end else begin
            chk({tag, " store rdata"}, rdata, last_rdata);
        end
    endtask

    task automatic do_misaligned(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [63:0] addr, input string tag);
        @(negedge clk);
        mem_read_M = rd; mem_write_M = wr; func3_M = f3; addr_M = addr;
        wdata_M = {$urandom, $urandom};
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = {$urandom, $urandom};
        #1;
        chk({tag, " misal"}, 64'(misaligned), 64'd1);
        chk({tag, " req"},   64'(dm_req), 64'd0);
        chk({tag, " stall"}, 64'(mem_stall), 64'd0);
        idle_cycle(tag);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [63:0] addr, wd, dword;
        int          gd, rvd;
        bit          same, mis;
        logic [7:0]  be;
        logic [63:0] ewd, erd;
    } vec_t;

    vec_t tbl[17];

    initial begin
        reset = 1'b1;
        mem_read_M = 1'b0; mem_write_M = 1'b0; func3_M = 3'd0;
        addr_M = 64'd0; wdata_M = 64'd0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 64'd0;

        //          rd    wr    f3    addr        wdata                  dword                  gd rvd same mis be     exp wdata              exp rdata
        tbl[0]  = '{1'b1, 1'b0, 3'd2, 64'h1004, 64'h0,                 64'h80000000_00000000, 0, 0, 1'b0, 1'b0, 8'hF0, 64'h0,                 64'hFFFFFFFF_80000000};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 64'h2003, 64'hAB,                64'h0,                 3, 0, 1'b0, 1'b0, 8'h08, 64'h00000000_AB000000, 64'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'd4, 64'h0007, 64'h0,                 64'hFF000000_00000000, 0, 0, 1'b1, 1'b0, 8'h80, 64'h0,                 64'h00000000_000000FF};
        tbl[3]  = '{1'b1, 1'b0, 3'd3, 64'h4000, 64'h0,                 64'h01234567_89ABCDEF, 0, 0, 1'b0, 1'b0, 8'hFF, 64'h0,                 64'h01234567_89ABCDEF};
        tbl[4]  = '{1'b0, 1'b1, 3'd3, 64'h4008, 64'h11223344_55667788, 64'h0,                 0, 0, 1'b0, 1'b0, 8'hFF, 64'h11223344_55667788, 64'h0};
        tbl[5]  = '{1'b1, 1'b0, 3'd1, 64'h0012, 64'h0,                 64'h00000000_80010000, 1, 2, 1'b0, 1'b0, 8'h0C, 64'h0,                 64'hFFFFFFFF_FFFF8001};
        tbl[6]  = '{1'b1, 1'b0, 3'd5, 64'h0016, 64'h0,                 64'hFEDC0000_00000000, 0, 1, 1'b0, 1'b0, 8'hC0, 64'h0,                 64'h00000000_0000FEDC};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 64'h0005, 64'h0,                 64'h00007F00_00000000, 2, 0, 1'b0, 1'b0, 8'h20, 64'h0,                 64'h00000000_0000007F};
        tbl[8]  = '{1'b1, 1'b0, 3'd6, 64'h0000, 64'h0,                 64'h00000000_F0000001, 0, 0, 1'b0, 1'b0, 8'h0F, 64'h0,                 64'h00000000_F0000001};
        tbl[9]  = '{1'b1, 1'b0, 3'd7, 64'h0008, 64'h0,                 64'hDEADBEEF_CAFEF00D, 2, 0, 1'b1, 1'b0, 8'hFF, 64'h0,                 64'hDEADBEEF_CAFEF00D};
        tbl[10] = '{1'b1, 1'b1, 3'd1, 64'h0026, 64'hBEEF,              64'h0,                 0, 0, 1'b0, 1'b0, 8'hC0, 64'hBEEF0000_00000000, 64'h0};
        tbl[11] = '{1'b0, 1'b1, 3'd2, 64'h0034, 64'h12345678,          64'h0,                 1, 1, 1'b0, 1'b0, 8'hF0, 64'h12345678_00000000, 64'h0};
        tbl[12] = '{1'b1, 1'b0, 3'd1, 64'h3001, 64'h0,                 64'h0,                 0, 0, 1'b0, 1'b1, 8'h00, 64'h0,                 64'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd2, 64'h0002, 64'h0,                 64'h0,                 0, 0, 1'b0, 1'b1, 8'h00, 64'h0,                 64'h0};
        tbl[14] = '{1'b1, 1'b0, 3'd3, 64'h0004, 64'h0,                 64'h0,                 0, 0, 1'b0, 1'b1, 8'h00, 64'h0,                 64'h0};
        tbl[15] = '{1'b0, 1'b1, 3'd1, 64'h1001, 64'h0,                 64'h0,                 0, 0, 1'b0, 1'b1, 8'h00, 64'h0,                 64'h0};
        tbl[16] = '{1'b1, 1'b0, 3'd6, 64'h0006, 64'h0,                 64'h0,                 0, 0, 1'b0, 1'b1, 8'h00, 64'h0,                 64'h0};

        // reset state, with an aligned load presented to prove outputs are forced
        @(negedge clk);
        mem_read_M = 1'b1; func3_M = 3'd3; addr_M = 64'h40;
        #1;
        chk("rst state", 64'(dbg_state_o), 64'(ST_IDLE));
        chk("rst rdata", rdata, 64'd0);
        chk("rst stall", 64'(mem_stall), 64'd0);
        chk("rst req",   64'(dm_req), 64'd0);
        addr_M = 64'h41;
        #1 chk("rst misal", 64'(misaligned), 64'd0);
        @(negedge clk);
        mem_read_M = 1'b0;
        reset = 1'b0;
        idle_cycle("post_rst");

        // directed table; entries 3 and 4 run back-to-back (ld then sd)
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].mis)
                do_misaligned(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, $sformatf("vec%0d", i));
            else
                do_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].dword,
                          tbl[i].gd, tbl[i].rvd, tbl[i].same, tbl[i].be, tbl[i].ewd, tbl[i].erd,
                          $sformatf("vec%0d", i));
            if (i == 2) idle_cycle("vec_gap");
        end
        idle_cycle("tbl_end");

        // reset during WAIT abandons the access; a late response is ignored
        do_access(1'b1, 1'b0, 3'd3, 64'h5008, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 0, 0, 1'b0,
                  8'hFF, 64'h0, 64'hA5A5A5A5_5A5A5A5A, "pre_rst");
        @(negedge clk);
        mem_read_M = 1'b1; mem_write_M = 1'b0; func3_M = 3'd2; addr_M = 64'h1000;
        dm_gnt = 1'b1; dm_rvalid = 1'b0;
        #1 chk("mid issue req", 64'(dm_req), 64'd1);
        @(negedge clk);
        dm_gnt = 1'b0;
        #1 chk("mid wait state", 64'(dbg_state_o), 64'(ST_WAIT));
        reset = 1'b1;
        #1;
        chk("mid rst state", 64'(dbg_state_o), 64'(ST_IDLE));
        chk("mid rst rdata", rdata, 64'd0);
        chk("mid rst stall", 64'(mem_stall), 64'd0);
        chk("mid rst req",   64'(dm_req), 64'd0);
        @(negedge clk);
        reset = 1'b0; mem_read_M = 1'b0;
        dm_rvalid = 1'b1; dm_rdata = 64'hFFFFFFFF_FFFFFFFF;
        #1 chk("late rv stall", 64'(mem_stall), 64'd0);
        @(negedge clk);
        dm_rvalid = 1'b0;
        #1;
        chk("late rv rdata", rdata, 64'd0);
        chk("late rv state", 64'(dbg_state_o), 64'(ST_IDLE));
        last_rdata = 64'd0;

        // randomized accesses against the byte model
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  f3;
            logic [63:0] addr, wd, dw;
            logic        rd, wr;
            int          off, sel, gd, rvd;
            bit          same;
            f3   = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 2);
            rd   = (sel != 1);
            wr   = (sel != 0);
            addr = {$urandom, $urandom};
            wd   = {$urandom, $urandom};
            dw   = {$urandom, $urandom};
            off  = int'(addr[2:0]);
            gd   = $urandom_range(0, 3);
            rvd  = $urandom_range(0, 3);
            same = ($urandom_range(0, 3) == 0);
            if ((off % size_bytes(f3)) != 0)
                do_misaligned(rd, wr, f3, addr, $sformatf("rnd%0d", n));
            else
                do_access(rd, wr, f3, addr, wd, dw, gd, rvd, same, model_be(f3, off),
                          wd << (8*off), model_load(f3, off, dw), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rnd%0d gap", n));
        end
        idle_cycle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
